// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start/halt control, sequential
// fetch, branch/call/return redirects with a small return-address stack.
module fetch_sequencer #(
  parameter int                  PC_W        = 8,
  parameter int                  INSTR_W     = 9,
  parameter logic [INSTR_W-1:0]  HALT_CODE   = 9'h1FF,
  parameter int                  STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               br_taken_i,
  input  logic               call_i,
  input  logic               ret_i,
  input  logic [PC_W-1:0]    br_target_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               fetch_valid_o,
  output logic               done_o,
  output logic               stack_err_o
);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              push;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];

  logic [PC_W-1:0]   pc_inc;
  logic [IDX_W-1:0]  top_idx;
  logic              stk_empty, stk_full;

  assign pc_inc    = pc_q + PC_W'(1);
  // sp counts entries, so the top entry sits one below it (wraps cleanly at sp==DEPTH)
  assign top_idx   = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          pc_d    = '0;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (!stall_i) begin
          if (instr_i == HALT_CODE) begin
            state_d = DONE;
          end else if (ret_i) begin
            if (!stk_empty) begin
              pc_d = stack_q[top_idx];
              sp_d = sp_q - SP_W'(1);
            end else begin
              err_d = 1'b1;
              pc_d  = pc_inc;
            end
          end else if (call_i) begin
            pc_d = br_target_i;
            if (stk_full) begin
              err_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_W'(1);
            end
          end else if (br_taken_i) begin
            pc_d = br_target_i;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = (state_q == RUN) && !stall_i;
  assign done_o        = (state_q == DONE);
  assign stack_err_o   = err_q;
endmodule
